// File: rtl/enemy_pass_scheduler.sv
// Enemy pass scheduler: each accepted frame_tick walks the plane slots, running
// load/erase/move/draw per visible slot on the shared datapath. Macro PASS_RATE_DIV_EN adds the tick divider.
module enemy_pass_scheduler #(
  parameter int MAX_PLANES = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic [3:0]            plane_amount,
  input  logic [MAX_PLANES-1:0] active,
  input  logic [1:0]            flying_rate,
  input  logic                  dp_done,
  output logic [3:0]            plane_sel,
  output logic [1:0]            op,
  output logic [2:0]            colour,
  output logic                  load_coord,
  output logic                  dp_go,
  output logic                  move_en,
  output logic                  busy,
  output logic                  pass_done,
  output logic                  overrun
);

  typedef enum logic [3:0] {
    IDLE, SCAN, LOAD, ERASE, WAIT_E, MOVE, DRAW, WAIT_D, DONE
  } state_t;

  localparam logic [3:0] LP_MAX  = 4'(MAX_PLANES);
  localparam logic [3:0] LP_LAST = 4'(MAX_PLANES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_index;
  logic [3:0] r_count;
  logic [3:0] w_count;
  logic       r_overrun;
  logic       w_accept;
  logic       w_activeBit;

`ifdef PASS_RATE_DIV_EN
  logic [1:0] r_rateCnt;

  assign w_accept = frame_tick && (r_rateCnt == flying_rate);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rateCnt <= 2'd0;
    end else if (frame_tick) begin
      r_rateCnt <= w_accept ? 2'd0 : r_rateCnt + 2'd1;
    end
  end
`else
  logic w_unusedRate;

  assign w_accept     = frame_tick;
  assign w_unusedRate = ^flying_rate;
`endif

  assign w_count     = (plane_amount > LP_MAX) ? LP_MAX : plane_amount;
  assign w_activeBit = (r_index < LP_MAX) ? active[r_index] : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SCAN;
      SCAN: begin
        if (r_index == r_count) begin
          w_next = DONE;
        end else if (w_activeBit) begin
          w_next = LOAD;
        end
      end
      LOAD:    w_next = ERASE;
      ERASE:   w_next = WAIT_E;
      WAIT_E:  if (dp_done) w_next = MOVE;
      MOVE:    w_next = DRAW;
      DRAW:    w_next = WAIT_D;
      WAIT_D:  if (dp_done) w_next = SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slot index and pass length are latched at pass start; overrun flags a tick that lands mid-pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index   <= 4'd0;
      r_count   <= 4'd0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_accept && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_index <= 4'd0;
            r_count <= w_count;
          end
        end
        SCAN:    if ((r_index != r_count) && !w_activeBit) r_index <= r_index + 4'd1;
        WAIT_D:  if (dp_done) r_index <= r_index + 4'd1;
        default: ;
      endcase
    end
  end

  // The end-of-pass index can reach MAX_PLANES, so the exported slot is clamped to the last real slot.
  always_comb begin
    plane_sel  = 4'd0;
    op         = 2'b00;
    colour     = 3'b000;
    load_coord = 1'b0;
    dp_go      = 1'b0;
    move_en    = 1'b0;
    busy       = (r_state != IDLE);
    pass_done  = 1'b0;
    overrun    = r_overrun;
    if (r_state != IDLE) begin
      plane_sel = (r_index > LP_LAST) ? LP_LAST : r_index;
    end
    case (r_state)
      LOAD:    load_coord = 1'b1;
      ERASE: begin
        dp_go = 1'b1;
        op    = 2'b01;
      end
      WAIT_E:  op = 2'b01;
      MOVE:    move_en = 1'b1;
      DRAW: begin
        dp_go  = 1'b1;
        op     = 2'b10;
        colour = 3'b111;
      end
      WAIT_D: begin
        op     = 2'b10;
        colour = 3'b111;
      end
      DONE:    pass_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_enemy_pass_scheduler.sv
// Bench for enemy_pass_scheduler: a queue-of-phases pass model checked every cycle,
// plus hand-computed totals per directed scenario. Honours PASS_RATE_DIV_EN like the design.
`timescale 1ns/1ps
module tb_enemy_pass_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic [3:0] plane_amount;
  logic [9:0] active;
  logic [1:0] flying_rate;
  logic       dp_done = 1'b0;
  logic [3:0] plane_sel;
  logic [1:0] op;
  logic [2:0] colour;
  logic       load_coord, dp_go, move_en, busy, pass_done, overrun;

  int checks = 0;
  int failures = 0;
  bit chkEn = 1'b0;
  int respLatency = 1;
  int respCnt = 0;

  int cntBusy = 0, cntGo = 0, cntMove = 0, cntDone = 0, cntOvr = 0, maxSel = 0;
  logic [31:0] moveSeq = 32'd0;
  int snapBusy, snapGo, snapMove, snapDone, snapOvr;

  typedef enum {PH_SCAN, PH_LOAD, PH_ERASE, PH_WAITE, PH_MOVE, PH_DRAW, PH_WAITD, PH_DONE} phase_e;
  typedef struct {
    phase_e kind;
    int     slot;
  } phase_t;
  phase_t plan[$];
  int  mRate = 0;
  bit  mOverrun = 1'b0;
  bit  mAcc, mWasBusy;

  enemy_pass_scheduler #(.MAX_PLANES(10)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .plane_amount(plane_amount),
    .active(active), .flying_rate(flying_rate), .dp_done(dp_done), .plane_sel(plane_sel),
    .op(op), .colour(colour), .load_coord(load_coord), .dp_go(dp_go), .move_en(move_en),
    .busy(busy), .pass_done(pass_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures < 40)
        $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Datapath stand-in: answers each dp_go with a dp_done pulse respLatency cycles later.
  always @(negedge clk) begin
    if (respCnt == 1) begin
      dp_done = 1'b1;
      respCnt = 0;
    end else begin
      dp_done = 1'b0;
      if (respCnt > 1) respCnt--;
    end
    if (dp_go) respCnt = respLatency;
  end

  function automatic void pushPh(input phase_e k, input int s);
    phase_t p;
    p.kind = k;
    p.slot = s;
    plan.push_back(p);
  endfunction

  function automatic void buildPlan();
    int n;
    n = (plane_amount > 4'd10) ? 10 : int'(plane_amount);
    for (int i = 0; i < n; i++) begin
      pushPh(PH_SCAN, i);
      if (active[i]) begin
        pushPh(PH_LOAD, i);  pushPh(PH_ERASE, i); pushPh(PH_WAITE, i);
        pushPh(PH_MOVE, i);  pushPh(PH_DRAW, i);  pushPh(PH_WAITD, i);
      end
    end
    pushPh(PH_SCAN, n);
    pushPh(PH_DONE, n);
  endfunction

  // Model: a pass is a list of phases; wait phases retire only on dp_done.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plan.delete();
      mRate = 0;
      mOverrun = 1'b0;
    end else begin
      mWasBusy = (plan.size() != 0);
      mAcc = frame_tick;
`ifdef PASS_RATE_DIV_EN
      if (frame_tick) begin
        if (mRate == int'(flying_rate)) begin
          mRate = 0;
        end else begin
          mAcc = 1'b0;
          mRate = (mRate + 1) % 4;
        end
      end
`endif
      mOverrun = mAcc && mWasBusy;
      if (mWasBusy) begin
        if (!((plan[0].kind == PH_WAITE || plan[0].kind == PH_WAITD) && !dp_done))
          void'(plan.pop_front());
      end else if (mAcc) begin
        buildPlan();
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus running totals.
  always @(posedge clk) begin
    logic [3:0] eSel;
    logic [1:0] eOp;
    logic [2:0] eCol;
    logic eLoad, eGo, eMove, eBusy, eDone;
    #1;
    if (reset_n && chkEn) begin
      eSel = 4'd0; eOp = 2'b00; eCol = 3'b000;
      eLoad = 1'b0; eGo = 1'b0; eMove = 1'b0; eBusy = 1'b0; eDone = 1'b0;
      if (plan.size() != 0) begin
        eBusy = 1'b1;
        eSel  = (plan[0].slot > 9) ? 4'd9 : 4'(plan[0].slot);
        case (plan[0].kind)
          PH_LOAD:  eLoad = 1'b1;
          PH_ERASE: begin eGo = 1'b1; eOp = 2'b01; end
          PH_WAITE: eOp = 2'b01;
          PH_MOVE:  eMove = 1'b1;
          PH_DRAW:  begin eGo = 1'b1; eOp = 2'b10; eCol = 3'b111; end
          PH_WAITD: begin eOp = 2'b10; eCol = 3'b111; end
          PH_DONE:  eDone = 1'b1;
          default: ;
        endcase
      end
      checkOutput("plane_sel", 32'(plane_sel), 32'(eSel));
      checkOutput("op", 32'(op), 32'(eOp));
      checkOutput("colour", 32'(colour), 32'(eCol));
      checkOutput("load_coord", 32'(load_coord), 32'(eLoad));
      checkOutput("dp_go", 32'(dp_go), 32'(eGo));
      checkOutput("move_en", 32'(move_en), 32'(eMove));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("pass_done", 32'(pass_done), 32'(eDone));
      checkOutput("overrun", 32'(overrun), 32'(mOverrun));
    end
    if (reset_n) begin
      cntBusy += int'(busy);
      cntGo   += int'(dp_go);
      cntMove += int'(move_en);
      cntDone += int'(pass_done);
      cntOvr  += int'(overrun);
      if (int'(plane_sel) > maxSel) maxSel = int'(plane_sel);
      if (move_en) moveSeq = {moveSeq[27:0], plane_sel};
    end
  end

  task automatic applyStimulus(input logic [3:0] amount, input logic [9:0] act, input int latency);
    plane_amount = amount;
    active       = act;
    respLatency  = latency;
    snapBusy = cntBusy; snapGo = cntGo; snapMove = cntMove; snapDone = cntDone; snapOvr = cntOvr;
  endtask

  task automatic pulseTick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while (busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, " pass ends"}, 32'(guard >= 2000), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitPhase(input string name, input logic [1:0] wantOp, input logic [3:0] wantSel);
    int guard = 0;
    while (!(op == wantOp && !dp_go && plane_sel == wantSel) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, " reached"}, 32'(guard >= 500), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " plane_sel"}, 32'(plane_sel), 32'd0);
    checkOutput({name, " op"}, 32'(op), 32'd0);
    checkOutput({name, " colour"}, 32'(colour), 32'd0);
    checkOutput({name, " load_coord"}, 32'(load_coord), 32'd0);
    checkOutput({name, " dp_go"}, 32'(dp_go), 32'd0);
    checkOutput({name, " move_en"}, 32'(move_en), 32'd0);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " pass_done"}, 32'(pass_done), 32'd0);
    checkOutput({name, " overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b1; frame_tick = 1'b0; plane_amount = 4'd0; active = 10'd0; flying_rate = 2'd0;
    #1 reset_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chkEn = 1'b1;
    @(negedge clk);

    // Three visible slots, dp_done two cycles after each dp_go: 9 cycles per slot + SCAN end + DONE.
    applyStimulus(4'd3, 10'b0000000111, 2);
    pulseTick();
    waitIdle("A");
    checkOutput("A busy cycles", 32'(cntBusy - snapBusy), 32'd29);
    checkOutput("A dp_go", 32'(cntGo - snapGo), 32'd6);
    checkOutput("A move_en", 32'(cntMove - snapMove), 32'd3);
    checkOutput("A pass_done", 32'(cntDone - snapDone), 32'd1);
    checkOutput("A move order", 32'(moveSeq[11:0]), 32'h012);

    // Oversized plane_amount clamps to ten slots at the 7-cycle minimum each.
    applyStimulus(4'd15, 10'h3FF, 1);
    pulseTick();
    waitIdle("B");
    checkOutput("B busy cycles", 32'(cntBusy - snapBusy), 32'd72);
    checkOutput("B dp_go", 32'(cntGo - snapGo), 32'd20);
    checkOutput("B move_en", 32'(cntMove - snapMove), 32'd10);
    checkOutput("B max plane_sel", 32'(maxSel), 32'd9);

    // Sparse mask: slots 0 and 2 cost one SCAN cycle each.
    applyStimulus(4'd4, 10'b0000001010, 1);
    pulseTick();
    waitIdle("C");
    checkOutput("C busy cycles", 32'(cntBusy - snapBusy), 32'd18);
    checkOutput("C dp_go", 32'(cntGo - snapGo), 32'd4);
    checkOutput("C move order", 32'(moveSeq[7:0]), 32'h13);

    // Empty pass: SCAN then DONE only.
    applyStimulus(4'd0, 10'h3FF, 1);
    pulseTick();
    waitIdle("D");
    checkOutput("D busy cycles", 32'(cntBusy - snapBusy), 32'd2);
    checkOutput("D dp_go", 32'(cntGo - snapGo), 32'd0);
    checkOutput("D pass_done", 32'(cntDone - snapDone), 32'd1);

    // Tick during WAIT_D of slot 1: overrun, no restart, no second pass.
    applyStimulus(4'd3, 10'b0000000111, 2);
    pulseTick();
    waitPhase("E wait_d slot1", 2'b10, 4'd1);
    pulseTick();
    waitIdle("E");
    repeat (20) @(negedge clk);
    checkOutput("E overrun", 32'(cntOvr - snapOvr), 32'd1);
    checkOutput("E pass_done", 32'(cntDone - snapDone), 32'd1);
    checkOutput("E busy cycles", 32'(cntBusy - snapBusy), 32'd29);

    // Reset inside WAIT_E; the datapath's late dp_done arrives after release.
    applyStimulus(4'd3, 10'b0000000111, 4);
    pulseTick();
    waitPhase("F wait_e slot0", 2'b01, 4'd0);
    #2 reset_n = 1'b0;
    #1 checkAllZero("F in reset");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(4'd3, 10'b0000000111, 4);
    repeat (12) @(negedge clk);
    checkOutput("F busy after release", 32'(cntBusy - snapBusy), 32'd0);
    checkOutput("F dp_go after release", 32'(cntGo - snapGo), 32'd0);
    checkOutput("F pass_done after release", 32'(cntDone - snapDone), 32'd0);

    // Nine spaced ticks with flying_rate=2.
    applyStimulus(4'd0, 10'd0, 1);
    flying_rate = 2'd2;
    for (int i = 0; i < 9; i++) begin
      pulseTick();
      repeat (6) @(negedge clk);
    end
`ifdef PASS_RATE_DIV_EN
    checkOutput("G passes", 32'(cntDone - snapDone), 32'd3);
`else
    checkOutput("G passes", 32'(cntDone - snapDone), 32'd9);
`endif
    checkOutput("G overrun", 32'(cntOvr - snapOvr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
